// File: rtl/pong_game_controller.sv
// Pong game sequencer: serve, rally, point and game-over phases.
// Optional macro RALLY_SPEEDUP_EN: ball speeds up as a rally goes on.
module pong_game_controller #(
  parameter int SCORE_WIDTH  = 4,
  parameter int WIN_SCORE    = 7,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 30
`ifdef RALLY_SPEEDUP_EN
  ,
  parameter int SPEED_STEP   = 4,
  parameter int MAX_SPEED    = 7
`endif
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   frame_tick,
  input  logic                   start,
  input  logic                   p1_hit,
  input  logic                   p2_hit,
  input  logic                   ball_out_left,
  input  logic                   ball_out_right,
  output logic                   ball_reset,
  output logic                   ball_enable,
  output logic                   serve_dir,
  output logic                   bounce_x,
  output logic [2:0]             ball_speed,
  output logic [SCORE_WIDTH-1:0] p1_score,
  output logic [SCORE_WIDTH-1:0] p2_score,
  output logic                   game_over,
  output logic                   winner,
  output logic [2:0]             state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    POINT = 3'd3,
    OVER  = 3'd4
  } st_e;

  localparam logic [SCORE_WIDTH-1:0] WinS  = SCORE_WIDTH'(WIN_SCORE);
  localparam logic [SCORE_WIDTH-1:0] ScMax = '1;
  localparam logic [7:0] SrvLd = 8'(SERVE_FRAMES - 1);
  localparam logic [7:0] PntLd = 8'(POINT_FRAMES - 1);

  st_e                    state_q;
  logic [7:0]             timer_q;
  logic [SCORE_WIDTH-1:0] p1_q;
  logic [SCORE_WIDTH-1:0] p2_q;
  logic                   brst_q;
  logic                   ben_q;
  logic                   dir_q;
  logic                   bnc_q;
  logic                   over_q;
  logic                   win_q;
  logic                   hprev_q;

  logic hit;
  logic out_any;
  logic won;
  logic bounce_d;
  logic go_serve;

  assign hit      = p1_hit | p2_hit;
  assign out_any  = ball_out_left | ball_out_right;
  assign won      = (p1_q == WinS) || (p2_q == WinS);
  assign bounce_d = (state_q == PLAY) && hit && !hprev_q
                    && !out_any;
  assign go_serve = (((state_q == IDLE) || (state_q == OVER))
                     && start)
                    || ((state_q == POINT) && !won
                        && frame_tick && (timer_q == 8'd0));

  // Game phase sequencer with registered ball/score outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      timer_q <= 8'd0;
      p1_q    <= '0;
      p2_q    <= '0;
      brst_q  <= 1'b1;
      ben_q   <= 1'b0;
      dir_q   <= 1'b0;
      bnc_q   <= 1'b0;
      over_q  <= 1'b0;
      win_q   <= 1'b0;
      hprev_q <= 1'b0;
    end else begin
      bnc_q   <= bounce_d;
      hprev_q <= hit;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= SERVE;
            p1_q    <= '0;
            p2_q    <= '0;
            timer_q <= SrvLd;
          end
        end
        SERVE: begin
          if (frame_tick) begin
            if (timer_q == 8'd0) begin
              state_q <= PLAY;
              brst_q  <= 1'b0;
              ben_q   <= 1'b1;
            end else begin
              timer_q <= timer_q - 8'd1;
            end
          end
        end
        PLAY: begin
          if (out_any) begin
            state_q <= POINT;
            timer_q <= PntLd;
            brst_q  <= 1'b1;
            ben_q   <= 1'b0;
            if (ball_out_left && !ball_out_right) begin
              if (p2_q != ScMax) p2_q <= p2_q + 1'b1;
              dir_q <= 1'b0;
            end
            if (ball_out_right && !ball_out_left) begin
              if (p1_q != ScMax) p1_q <= p1_q + 1'b1;
              dir_q <= 1'b1;
            end
          end
        end
        POINT: begin
          if (won) begin
            state_q <= OVER;
            over_q  <= 1'b1;
            win_q   <= (p2_q == WinS);
          end else if (frame_tick) begin
            if (timer_q == 8'd0) begin
              state_q <= SERVE;
              timer_q <= SrvLd;
            end else begin
              timer_q <= timer_q - 8'd1;
            end
          end
        end
        OVER: begin
          if (start) begin
            state_q <= SERVE;
            p1_q    <= '0;
            p2_q    <= '0;
            over_q  <= 1'b0;
            dir_q   <= ~win_q;
            timer_q <= SrvLd;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef RALLY_SPEEDUP_EN
  localparam logic [7:0] StepLast = 8'(SPEED_STEP - 1);
  localparam logic [2:0] SpdMax   = 3'(MAX_SPEED);

  logic [7:0] hits_q;
  logic [2:0] spd_q;

  // Count rally hits; bump speed every SPEED_STEP hits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hits_q <= 8'd0;
      spd_q  <= 3'd1;
    end else if (go_serve) begin
      hits_q <= 8'd0;
      spd_q  <= 3'd1;
    end else if (bounce_d) begin
      if (hits_q == StepLast) begin
        hits_q <= 8'd0;
        if (spd_q < SpdMax) spd_q <= spd_q + 3'd1;
      end else begin
        hits_q <= hits_q + 8'd1;
      end
    end
  end

  assign ball_speed = spd_q;
`else
  logic unused_serve;
  assign unused_serve = go_serve;
  assign ball_speed   = 3'd1;
`endif

  assign ball_reset  = brst_q;
  assign ball_enable = ben_q;
  assign serve_dir   = dir_q;
  assign bounce_x    = bnc_q;
  assign p1_score    = p1_q;
  assign p2_score    = p2_q;
  assign game_over   = over_q;
  assign winner      = win_q;
  assign state       = state_q;

endmodule

// File: tb/tb_pong_game_controller.sv
// Bench for pong_game_controller: phase model plus directed scenarios.
// Compare at negedge; inputs change 1 time unit after posedge.
module tb_pong_game_controller;

  localparam int SW  = 4;
  localparam int WIN = 7;
  localparam int SF  = 60;
  localparam int PF  = 30;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic frame_tick = 1'b0;
  logic start = 1'b0;
  logic p1_hit = 1'b0;
  logic p2_hit = 1'b0;
  logic ball_out_left = 1'b0;
  logic ball_out_right = 1'b0;
  logic ball_reset;
  logic ball_enable;
  logic serve_dir;
  logic bounce_x;
  logic [2:0] ball_speed;
  logic [SW-1:0] p1_score;
  logic [SW-1:0] p2_score;
  logic game_over;
  logic winner;
  logic [2:0] state;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pong_game_controller dut (
    .clk(clk),
    .rst(rst),
    .frame_tick(frame_tick),
    .start(start),
    .p1_hit(p1_hit),
    .p2_hit(p2_hit),
    .ball_out_left(ball_out_left),
    .ball_out_right(ball_out_right),
    .ball_reset(ball_reset),
    .ball_enable(ball_enable),
    .serve_dir(serve_dir),
    .bounce_x(bounce_x),
    .ball_speed(ball_speed),
    .p1_score(p1_score),
    .p2_score(p2_score),
    .game_over(game_over),
    .winner(winner),
    .state(state)
  );

  task automatic chk(input string nm, input int act,
                     input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Phase model: 0 idle,1 serve,2 play,3 point,4 over.
  int m_ph = 0;
  int m_ticks = 0;
  int m_s1 = 0;
  int m_s2 = 0;
  int m_hits = 0;
  bit m_dir = 0;
  bit m_win = 0;
  bit m_bnc = 0;
  bit m_prev = 0;
  bit m_h = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_ph = 0; m_ticks = 0; m_s1 = 0; m_s2 = 0;
      m_hits = 0; m_dir = 0; m_win = 0;
      m_bnc = 0; m_prev = 0;
    end else begin
      m_h = p1_hit | p2_hit;
      m_bnc = 0;
      case (m_ph)
        0: if (start) begin
          m_ph = 1; m_s1 = 0; m_s2 = 0;
          m_ticks = 0; m_hits = 0;
        end
        1: if (frame_tick) begin
          m_ticks++;
          if (m_ticks == SF) m_ph = 2;
        end
        2: if (ball_out_left || ball_out_right) begin
          if (ball_out_left && !ball_out_right) begin
            m_s2++; m_dir = 0;
          end else if (ball_out_right && !ball_out_left) begin
            m_s1++; m_dir = 1;
          end
          m_ph = 3; m_ticks = 0;
        end else if (m_h && !m_prev) begin
          m_bnc = 1; m_hits++;
        end
        3: if (m_s1 == WIN || m_s2 == WIN) begin
          m_ph = 4; m_win = (m_s2 == WIN);
        end else if (frame_tick) begin
          m_ticks++;
          if (m_ticks == PF) begin
            m_ph = 1; m_ticks = 0; m_hits = 0;
          end
        end
        4: if (start) begin
          m_ph = 1; m_s1 = 0; m_s2 = 0;
          m_dir = !m_win; m_ticks = 0; m_hits = 0;
        end
        default: ;
      endcase
      m_prev = m_h;
    end
  end

  function automatic int exp_speed();
`ifdef RALLY_SPEEDUP_EN
    int s;
    s = 1 + m_hits / 4;
    return (s > 7) ? 7 : s;
`else
    return 1;
`endif
  endfunction

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    chk("state", int'(state), m_ph);
    chk("ball_reset", int'(ball_reset), int'(m_ph != 2));
    chk("ball_enable", int'(ball_enable), int'(m_ph == 2));
    chk("serve_dir", int'(serve_dir), int'(m_dir));
    chk("bounce_x", int'(bounce_x), int'(m_bnc));
    chk("ball_speed", int'(ball_speed), exp_speed());
    chk("p1_score", int'(p1_score), m_s1);
    chk("p2_score", int'(p2_score), m_s2);
    chk("game_over", int'(game_over), int'(m_ph == 4));
    if (m_ph == 4) chk("winner", int'(winner), int'(m_win));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      cyc();
      frame_tick = 1'b0;
      cyc();
    end
  endtask

  task automatic hitpulse();
    p2_hit = 1'b1;
    cyc();
    p2_hit = 1'b0;
    cyc();
  endtask

  int nb;

  initial begin
    #2 rst = 1'b0;
    cyc();
    cyc();
    chk("rst_state", int'(state), 0);
    chk("rst_ball_reset", int'(ball_reset), 1);
    chk("rst_ball_enable", int'(ball_enable), 0);
    chk("rst_speed", int'(ball_speed), 1);
    chk("rst_winner", int'(winner), 0);
    rst = 1'b1;
    cyc();

    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("start_serve", int'(state), 1);
    ticks(59);
    chk("serve_hold", int'(state), 1);
    chk("serve_en_low", int'(ball_enable), 0);
    ticks(1);
    chk("play_entry", int'(state), 2);
    chk("play_enable", int'(ball_enable), 1);

    nb = 0;
    p1_hit = 1'b1;
    start = 1'b1;
    repeat (5) begin
      cyc();
      nb += int'(bounce_x);
    end
    p1_hit = 1'b0;
    start = 1'b0;
    repeat (3) begin
      cyc();
      nb += int'(bounce_x);
    end
    chk("held_hit_pulses", nb, 1);
    p2_hit = 1'b1;
    cyc();
    chk("p2_bounce", int'(bounce_x), 1);
    p2_hit = 1'b0;
    cyc();
    chk("bounce_clear", int'(bounce_x), 0);

    ball_out_right = 1'b1;
    cyc();
    ball_out_right = 1'b0;
    chk("right_p1", int'(p1_score), 1);
    chk("right_dir", int'(serve_dir), 1);
    chk("right_point", int'(state), 3);
    ticks(29);
    chk("point_hold", int'(state), 3);
    ticks(1);
    chk("point_to_serve", int'(state), 1);
    ticks(SF);

    p1_hit = 1'b1;
    ball_out_left = 1'b1;
    cyc();
    p1_hit = 1'b0;
    ball_out_left = 1'b0;
    chk("hitout_bounce", int'(bounce_x), 0);
    chk("hitout_p2", int'(p2_score), 1);
    chk("hitout_dir", int'(serve_dir), 0);
    ticks(PF);
    ticks(SF);

    ball_out_left = 1'b1;
    ball_out_right = 1'b1;
    cyc();
    ball_out_left = 1'b0;
    ball_out_right = 1'b0;
    chk("both_point", int'(state), 3);
    chk("both_p1", int'(p1_score), 1);
    chk("both_p2", int'(p2_score), 1);
    chk("both_dir", int'(serve_dir), 0);
    ticks(PF);
    ticks(SF);

    for (int i = 2; i <= WIN; i++) begin
      ball_out_right = 1'b1;
      cyc();
      ball_out_right = 1'b0;
      if (i < WIN) begin
        ticks(PF);
        ticks(SF);
      end
    end
    chk("win_p1", int'(p1_score), 7);
    cyc();
    chk("over_state", int'(state), 4);
    chk("over_flag", int'(game_over), 1);
    chk("over_winner", int'(winner), 0);
    ticks(3);
    chk("over_held", int'(p1_score), 7);

    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("restart_state", int'(state), 1);
    chk("restart_p1", int'(p1_score), 0);
    chk("restart_dir", int'(serve_dir), 1);
    chk("restart_over", int'(game_over), 0);
    ticks(SF);

`ifdef RALLY_SPEEDUP_EN
    repeat (8) hitpulse();
    chk("speed_8", int'(ball_speed), 3);
    repeat (22) hitpulse();
    chk("speed_30", int'(ball_speed), 7);
    ball_out_right = 1'b1;
    cyc();
    ball_out_right = 1'b0;
    ticks(PF);
    chk("speed_serve", int'(ball_speed), 1);
    ticks(SF);
`else
    repeat (5) hitpulse();
    chk("speed_const", int'(ball_speed), 1);
`endif

    ball_out_left = 1'b1;
    cyc();
    ball_out_left = 1'b0;
    ticks(PF);
    ticks(SF);
    chk("pre_abort_play", int'(state), 2);
    rst = 1'b0;
    #1;
    chk("abort_state", int'(state), 0);
    chk("abort_enable", int'(ball_enable), 0);
    chk("abort_reset", int'(ball_reset), 1);
    chk("abort_p2", int'(p2_score), 0);
    cyc();
    rst = 1'b1;
    cyc();
    chk("abort_idle", int'(state), 0);
    repeat (3) cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
